mem_sp_req_ctrl: RTL and testbench

Request front-end for the single-port SRAM wrapper `mem_sp_sky130`. It accepts read and write requests on a valid/ready port and drives the wrapper's `addr/wen/wdata/bwe/ren` pins. It tracks the macro's fixed read latency and captures `rdata` into a small response FIFO, so downstream consumers can apply backpressure without losing data. Optionally, it zero-fills the array after reset, because macro contents power up as X.

---
 rtl/mem_sp_req_ctrl_pkg.sv | 16 +
 rtl/mem_sp_req_ctrl_rsp_fifo.sv | 61 ++++++
 rtl/mem_sp_req_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_sp_req_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sp_req_ctrl_pkg.sv
`default_nettype none
// mem_sp_ctrl_pkg: state encoding and sizing helper shared by the SRAM request front-end.
package mem_sp_ctrl_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width needed to count 0..depth entries inclusive.
  function automatic int cnt_bit(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sp_req_ctrl_rsp_fifo.sv
`default_nettype none
// mem_sp_rsp_fifo: synchronous response FIFO; pointers wrap modulo RSP_DEPTH (any depth).
module mem_sp_rsp_fifo
  import mem_sp_ctrl_pkg::*;
#(
  parameter int DATA_BIT  = 32,
  parameter int RSP_DEPTH = 4,
  parameter int CNT_BIT   = cnt_bit(RSP_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DATA_BIT-1:0] push_data,
  input  logic                pop,
  output logic [DATA_BIT-1:0] pop_data,
  output logic [CNT_BIT-1:0]  count
);

  localparam int PTR_BIT = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_BIT-1:0] store [RSP_DEPTH];
  logic [PTR_BIT-1:0]  wr_ptr;
  logic [PTR_BIT-1:0]  rd_ptr;
  logic                do_push;
  logic                do_pop;

  function automatic logic [PTR_BIT-1:0] ptr_inc(input logic [PTR_BIT-1:0] p);
    return (p == PTR_BIT'(RSP_DEPTH - 1)) ? '0 : p + PTR_BIT'(1);
  endfunction

  // A pop frees the head slot in the same edge, so a push at full is allowed alongside it.
  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CNT_BIT'(RSP_DEPTH)) || do_pop);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_BIT'(1);
        2'b01:   count <= count - CNT_BIT'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_sp_req_ctrl.sv
`default_nettype none
// mem_sp_req_ctrl: valid/ready front-end for the mem_sp_sky130 single-port SRAM wrapper.
// Build option: define MEM_SP_CTRL_INIT_EN to zero-fill the array after every reset.
module mem_sp_req_ctrl
  import mem_sp_ctrl_pkg::*;
#(
  parameter int DATA_BIT  = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_BIT  = $clog2(DEPTH),
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_BIT-1:0] req_addr,
  input  logic [DATA_BIT-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_BIT-1:0] rsp_rdata,
  output logic [ADDR_BIT-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_BIT-1:0] mem_wdata,
  output logic [DATA_BIT-1:0] mem_bwe,
  output logic                mem_ren,
  input  logic [DATA_BIT-1:0] mem_rdata,
  output logic                init_done
);

  localparam int CNT_BIT = cnt_bit(RSP_DEPTH);

  logic                accept;
  logic                rd_issue;
  logic                rsp_pop;
  logic                init_wr;
  logic [ADDR_BIT-1:0] init_addr;
  logic [RD_LAT:0]     rd_tag;
  logic [CNT_BIT-1:0]  occ;

`ifdef MEM_SP_CTRL_INIT_EN
  state_e            state;
  state_e            state_nxt;
  logic [ADDR_BIT:0] init_cnt;
  logic [ADDR_BIT:0] init_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // The counter runs one past DEPTH-1 so RUN starts after the last fill write is on the pins.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_wr      = 1'b0;
    case (state)
      INIT: begin
        if (init_cnt == (ADDR_BIT + 1)'(DEPTH)) begin
          state_nxt = RUN;
        end else begin
          init_wr      = 1'b1;
          init_cnt_nxt = init_cnt + (ADDR_BIT + 1)'(1);
        end
      end
      default: ;
    endcase
  end

  assign init_done = (state == RUN);
  assign init_addr = init_cnt[ADDR_BIT-1:0];
`else
  logic run;

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign init_done = run;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  // Every outstanding read owns a FIFO slot; a same-cycle pop is deliberately not credited.
  assign req_ready = init_done && ((int'(occ) + $countones(rd_tag)) < RSP_DEPTH);
  assign accept    = req_valid && req_ready;
  assign rd_issue  = accept && !req_wr;
  assign mem_bwe   = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_wen <= init_wr || (accept && req_wr);
      mem_ren <= rd_issue;
      if (init_wr) begin
        mem_addr  <= init_addr;
        mem_wdata <= '0;
      end else if (accept) begin
        mem_addr <= req_addr;
        if (req_wr) begin
          mem_wdata <= req_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tag <= '0;
    end else begin
      rd_tag[0] <= rd_issue;
      for (int i = 1; i <= RD_LAT; i++) begin
        rd_tag[i] <= rd_tag[i-1];
      end
    end
  end

  assign rsp_valid = (occ != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;

  mem_sp_rsp_fifo #(
    .DATA_BIT  (DATA_BIT),
    .RSP_DEPTH (RSP_DEPTH),
    .CNT_BIT   (CNT_BIT)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_tag[RD_LAT]),
    .push_data (mem_rdata),
    .pop       (rsp_pop),
    .pop_data  (rsp_rdata),
    .count     (occ)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_sp_req_ctrl.sv
`default_nettype none
// tb_mem_sp_req_ctrl: directed bench for mem_sp_req_ctrl driving a behavioural single-port SRAM.
module tb_mem_sp_req_ctrl;

  localparam int DATA_BIT  = 32;
  localparam int DEPTH     = 256;
  localparam int ADDR_BIT  = 8;
  localparam int RD_LAT    = 1;
  localparam int RSP_DEPTH = 4;
`ifdef MEM_SP_CTRL_INIT_EN
  localparam int INIT_CYC  = DEPTH + 1;
  localparam int FILL_N    = DEPTH;
`else
  localparam int INIT_CYC  = 1;
  localparam int FILL_N    = 0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                fill = 1'b1;
  logic                req_valid, req_ready, req_wr;
  logic [ADDR_BIT-1:0] req_addr;
  logic [DATA_BIT-1:0] req_wdata;
  logic                rsp_valid, rsp_ready;
  logic [DATA_BIT-1:0] rsp_rdata;
  logic [ADDR_BIT-1:0] mem_addr;
  logic                mem_wen, mem_ren;
  logic [DATA_BIT-1:0] mem_wdata, mem_bwe, mem_rdata;
  logic                init_done;

  logic [DATA_BIT-1:0] sram [DEPTH];
  logic [DATA_BIT-1:0] rsp_q [$];
  int                  rcyc_q [$];
  int                  cyc = 0;
  int                  tests = 0;
  int                  fails = 0;
  int                  acc [16];

  mem_sp_req_ctrl #(
    .DATA_BIT  (DATA_BIT),
    .DEPTH     (DEPTH),
    .ADDR_BIT  (ADDR_BIT),
    .RD_LAT    (RD_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_bwe   (mem_bwe),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM with a one-cycle read: rdata is valid in the cycle after ren. Preloaded with a nonzero pattern.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (mem_wen) begin
      sram[mem_addr] <= mem_wdata;
    end
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      rsp_q.push_back(rsp_rdata);
      rcyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves req_valid high so consecutive calls issue back-to-back.
  task automatic send(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output int acc_cyc, output int waited);
    waited    = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) chk("send_ready_timeout", req_ready, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
  endtask

  task automatic get_rsp(input int idx, output logic [31:0] d, output int c);
    int n = 0;
    while (rsp_q.size() <= idx && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_q.size() > idx) begin
      d = rsp_q[idx];
      c = rcyc_q[idx];
    end else begin
      d = '1;
      c = -1;
      chk("rsp_missing", rsp_q.size(), idx + 1);
    end
  endtask

  // Called right after reset is released; checks ready-off time and the zero-fill write stream.
  task automatic wait_init(input string tag);
    int n = 0, low = 0, wr = 0, bad = 0;
    while (!init_done && n < 1000) begin
      if (!req_ready) low++;
      @(posedge clk); #1;
      n++;
      if (mem_wen) begin
        if (mem_addr != wr[7:0] || mem_wdata != 0) bad++;
        wr++;
      end
    end
    chk({tag, "_cycles"}, n, INIT_CYC);
    chk({tag, "_ready_low"}, low, INIT_CYC);
    chk({tag, "_fill_writes"}, wr, FILL_N);
    chk({tag, "_fill_bad"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, w, base, n, c, prev, stalls, acc_n;
    logic [31:0] d;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    fill = 1'b0;

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_bwe", mem_bwe, 32'hFFFF_FFFF);
    chk("rst_init_done", init_done, 0);

`ifdef MEM_SP_CTRL_INIT_EN
    rst = 1'b0;
    n = 0;
    while (!(mem_wen && mem_addr == 8'd100) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_reach_100", mem_addr, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midinit_rst_wen", mem_wen, 0);
    chk("midinit_rst_addr", mem_addr, 0);
    chk("midinit_rst_done", init_done, 0);
`endif
    rst = 1'b0;
    wait_init("init");

`ifdef MEM_SP_CTRL_INIT_EN
    base = rsp_q.size();
    send(0, 8'd0, 0, a, w);
    send(0, 8'd128, 0, a, w);
    send(0, 8'd255, 0, a, w);
    req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      get_rsp(base + k, d, c);
      chk("zero_fill_read", d, 0);
    end
`endif

    // Eight writes then eight reads, checking data order and accept-to-valid latency.
    for (int i = 0; i < 8; i++) send(1, 8'(i), 32'hA5A5_0000 + 32'(i), a, w);
    base = rsp_q.size();
    for (int i = 0; i < 8; i++) begin
      send(0, 8'(i), 0, a, w);
      acc[i] = a;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      get_rsp(base + i, d, c);
      chk("t1_data", d, 32'hA5A5_0000 + 32'(i));
      chk("t1_latency", c - acc[i], 1 + RD_LAT);
    end

    // Sixteen back-to-back reads must stream without a stall.
    base   = rsp_q.size();
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send(0, 8'(i % 8), 0, a, w);
      stalls += w;
    end
    req_valid = 1'b0;
    chk("t2_stalls", stalls, 0);
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      get_rsp(base + i, d, c);
      chk("t2_data", d, 32'hA5A5_0000 + 32'(i % 8));
      if (i > 0) chk("t2_gap", c - prev, 1);
      prev = c;
    end

    // Backpressure: only RSP_DEPTH reads may be accepted while rsp_ready is low.
    rsp_ready = 1'b0;
    base      = rsp_q.size();
    acc_n     = 0;
    req_wr    = 1'b0;
    for (int cc = 0; cc < 10; cc++) begin
      req_valid = (acc_n < 6);
      req_addr  = 8'(acc_n);
      if (req_valid && req_ready) acc_n++;
      @(posedge clk); #1;
    end
    chk("t3_accepted", acc_n, 4);
    chk("t3_ready_low", req_ready, 0);
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_head", rsp_rdata, 32'hA5A5_0000);
    rsp_ready = 1'b1;
    for (int cc = 0; cc < 30; cc++) begin
      req_valid = (acc_n < 6);
      req_addr  = 8'(acc_n);
      if (req_valid && req_ready) acc_n++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("t3_all_accepted", acc_n, 6);
    for (int k = 0; k < 6; k++) begin
      get_rsp(base + k, d, c);
      chk("t3_data", d, 32'hA5A5_0000 + 32'(k));
    end

    // Read immediately after a write to the same address.
    base = rsp_q.size();
    send(1, 8'd5, 32'hDEAD_BEEF, a, w);
    send(0, 8'd5, 0, a, w);
    req_valid = 1'b0;
    chk("raw_back_to_back", w, 0);
    get_rsp(base, d, c);
    chk("raw_same_addr", d, 32'hDEAD_BEEF);

    // Reset with two reads in flight must drop both responses.
    base = rsp_q.size();
    send(0, 8'd1, 0, a, w);
    send(0, 8'd2, 0, a, w);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_rsp_valid", rsp_valid, 0);
    chk("flush_req_ready", req_ready, 0);
    rst = 1'b0;
    wait_init("reinit");
    repeat (5) @(posedge clk);
    #1;
    chk("flush_no_rsp", rsp_q.size(), base);
    chk("flush_ready_back", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
